// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU datapath and a host port.
// The host is granted only at instruction boundaries, and a cycle quota bounds each session.
module mem_port_arbiter #(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 8,
    parameter int HOST_QUOTA = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cpu_phase,
    input  logic              cpu_halted,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              host_req,
    output logic              host_gnt,
    input  logic              host_valid,
    input  logic              host_wr,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [1:0] CPU_OWN  = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] HOST_OWN = 2'd2;
    localparam logic [1:0] COOL     = 2'd3;

    localparam int CW = (HOST_QUOTA > 1) ? $clog2(HOST_QUOTA) : 1;
    localparam logic [CW-1:0] QUOTA_LAST = CW'((HOST_QUOTA == 0) ? 0 : HOST_QUOTA - 1);

    logic [1:0]        state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              cpu_stall_reg;
    logic              host_gnt_reg;
    logic              host_rvalid_reg;
    logic [DWIDTH-1:0] host_rdata_reg;

    logic host_sel;
    logic boundary;
    logic quota_hit;
    logic rd_fire;

    assign host_sel  = (state_reg == HOST_OWN);
    // A halted CPU is not mid-instruction, so it counts as a boundary at any phase.
    assign boundary  = (cpu_phase == 3'd7) | cpu_halted;
    assign quota_hit = (HOST_QUOTA != 0) && (count_reg == QUOTA_LAST);
    assign rd_fire   = host_sel & host_valid & ~host_wr;

    always_comb begin
        state_next = state_reg;
        count_next = '0;
        case (state_reg)
            CPU_OWN: begin
                if (host_req) begin
                    state_next = cpu_halted ? HOST_OWN : DRAIN;
                end
            end
            DRAIN, COOL: begin
                if (!host_req) begin
                    state_next = CPU_OWN;
                end else if (boundary) begin
                    state_next = HOST_OWN;
                end
            end
            HOST_OWN: begin
                if (!host_req) begin
                    state_next = CPU_OWN;
                end else if (quota_hit) begin
                    state_next = COOL;
                end else begin
                    count_next = (HOST_QUOTA != 0) ? count_reg + 1'b1 : '0;
                end
            end
            default: state_next = CPU_OWN;
        endcase
    end

    // Stall and grant are registered from the next state so they rise together with the phase wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= CPU_OWN;
            count_reg       <= '0;
            cpu_stall_reg   <= 1'b0;
            host_gnt_reg    <= 1'b0;
            host_rvalid_reg <= 1'b0;
            host_rdata_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            cpu_stall_reg   <= (state_next == HOST_OWN);
            host_gnt_reg    <= (state_next == HOST_OWN);
            host_rvalid_reg <= rd_fire;
            if (rd_fire) begin
                host_rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_stall   = cpu_stall_reg;
    assign host_gnt    = host_gnt_reg;
    assign host_rvalid = host_rvalid_reg;
    assign host_rdata  = host_rdata_reg;

    assign mem_addr  = host_sel ? host_addr  : cpu_addr;
    assign mem_wdata = host_sel ? host_wdata : cpu_wdata;
    assign mem_rd    = host_sel ? (host_valid & ~host_wr) : cpu_rd;
    assign mem_wr    = host_sel ? (host_valid &  host_wr) : cpu_wr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: ownership/quota reference model plus a read-response scoreboard.
module tb_mem_port_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int QUOTA = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cpu_phase;
    logic          cpu_halted;
    logic [AW-1:0] cpu_addr;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          host_req;
    logic          host_gnt;
    logic          host_valid;
    logic          host_wr;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .HOST_QUOTA(QUOTA)) dut (
        .clk(clk), .rst(rst),
        .cpu_phase(cpu_phase), .cpu_halted(cpu_halted),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .host_req(host_req), .host_gnt(host_gnt),
        .host_valid(host_valid), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment: memory with combinational read, and a CPU phase counter gated by stall/halt.
    logic [DW-1:0] mem [0:31];
    logic [2:0]    phase;
    int            cyc = 0;

    assign mem_rdata = mem[mem_addr];
    assign cpu_phase = phase;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 3'd0;
        else if (!cpu_halted && !cpu_stall) phase <= phase + 3'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns memory, how long the host has held it, and whether it waits for a boundary.
    bit            m_gnt, m_wait;
    int            m_used;
    bit            g_n, w_n;
    int            u_n;
    logic [DW-1:0] ref_mem [0:31];
    int            exp_cyc_q[$];
    logic [DW-1:0] exp_dat_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gnt  <= 1'b0;
            m_wait <= 1'b0;
            m_used <= 0;
            for (int i = 0; i < 32; i++) ref_mem[i] <= '0;
            exp_cyc_q.delete();
            exp_dat_q.delete();
        end else begin
            if (m_gnt && host_valid) begin
                if (host_wr) ref_mem[host_addr] <= host_wdata;
                else begin
                    exp_cyc_q.push_back(cyc + 1);
                    exp_dat_q.push_back(ref_mem[host_addr]);
                end
            end else if (!m_gnt && cpu_wr) begin
                ref_mem[cpu_addr] <= cpu_wdata;
            end
            g_n = m_gnt;
            w_n = m_wait;
            u_n = m_used;
            if (!host_req) begin
                g_n = 1'b0; w_n = 1'b0; u_n = 0;
            end else if (m_gnt) begin
                u_n = u_n + 1;
                if (QUOTA != 0 && u_n == QUOTA) begin
                    g_n = 1'b0; w_n = 1'b1; u_n = 0;
                end
            end else if (m_wait) begin
                if (phase == 3'd7 || cpu_halted) begin
                    g_n = 1'b1; w_n = 1'b0;
                end
            end else if (cpu_halted) begin
                g_n = 1'b1;
            end else begin
                w_n = 1'b1;
            end
            m_gnt  <= g_n;
            m_wait <= w_n;
            m_used <= u_n;
        end
    end

    // Monitor: ownership/mux check every cycle, and read responses popped from the scoreboard.
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rd, e_wr;
    int            e_cyc;
    logic [DW-1:0] e_dat;

    always @(negedge clk) begin
        e_addr  = m_gnt ? host_addr : cpu_addr;
        e_wdata = m_gnt ? host_wdata : cpu_wdata;
        e_rd    = m_gnt ? (host_valid & ~host_wr) : cpu_rd;
        e_wr    = m_gnt ? (host_valid & host_wr) : cpu_wr;
        check("gnt_stall_mux", {host_gnt, cpu_stall, mem_addr, mem_rd, mem_wr, mem_wdata},
              {m_gnt, m_gnt, e_addr, e_rd, e_wr, e_wdata});
        if (cpu_stall && phase != 3'd0) check("stall_boundary", cpu_halted, 1);
        if (host_rvalid) begin
            if (exp_cyc_q.size() == 0) begin
                check("rvalid_spurious", host_rvalid, 0);
            end else begin
                e_cyc = exp_cyc_q.pop_front();
                e_dat = exp_dat_q.pop_front();
                check("rd_cycle", cyc, e_cyc);
                check("rd_data", host_rdata, e_dat);
                $display("host read response cycle %0d data 0x%02h", cyc, host_rdata);
            end
        end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
            check("rvalid_missing", host_rvalid, 1);
            e_cyc = exp_cyc_q.pop_front();
            e_dat = exp_dat_q.pop_front();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cpu();
        cpu_addr  = AW'($urandom);
        cpu_rd    = 1'($urandom_range(1));
        cpu_wr    = rst ? 1'b0 : ($urandom_range(3) == 0);
        cpu_wdata = DW'($urandom);
    endtask

    int k;
    int gc;

    initial begin
        rst = 1'b1;
        cpu_halted = 1'b0; host_req = 1'b0; host_valid = 1'b0; host_wr = 1'b0;
        host_addr = '0; host_wdata = '0;
        rand_cpu();
        repeat (3) step();
        check("reset_outputs", {host_gnt, cpu_stall, host_rvalid, host_rdata}, 0);
        rst = 1'b0;
        rand_cpu();

        // Request at phase 2: wait through DRAIN until the phase-7 edge.
        k = 0;
        while (phase != 3'd2 && k < 20) begin rand_cpu(); step(); k++; end
        check("reach_phase2", phase, 2);
        host_req = 1'b1;
        k = 0;
        while (!host_gnt && k < 30) begin rand_cpu(); step(); k++; end
        check("drain_edges", k, 6);
        check("phase_at_grant", phase, 0);

        // Write 0xA5 @5, read it back; then count the quota-limited session length.
        gc = 1;
        host_valid = 1'b1; host_wr = 1'b1; host_addr = 5; host_wdata = 8'hA5;
        rand_cpu(); step();
        if (host_gnt) gc++;
        host_wr = 1'b0;
        rand_cpu(); step();
        check("rd_pulse_a5", {host_rvalid, host_rdata}, {1'b1, 8'hA5});
        if (host_gnt) gc++;
        host_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_cpu(); step();
            if (host_gnt) gc++;
            else break;
        end
        check("quota_cycles", gc, QUOTA);
        check("rvalid_single", host_rvalid, 0);
        k = 0;
        while (!host_gnt && k < 30) begin rand_cpu(); step(); k++; end
        check("cool_edges", k, 8);
        host_req = 1'b0;
        step(); step();

        // Halted CPU: grant regardless of phase.
        cpu_halted = 1'b1;
        step(); step();
        host_req = 1'b1;
        k = 0;
        while (!host_gnt && k < 10) begin rand_cpu(); step(); k++; end
        check("halted_grant_edges", k <= 2, 1);
        for (int i = 0; i < 6; i++) begin
            host_valid = 1'b1; host_wr = 1'($urandom_range(1));
            host_addr = AW'($urandom_range(7)); host_wdata = DW'($urandom);
            rand_cpu(); step();
        end
        host_valid = 1'b0; host_req = 1'b0;
        step();
        cpu_halted = 1'b0;
        step(); step();

        // Host accesses without a grant are dropped.
        for (int i = 0; i < 10; i++) begin
            host_valid = 1'b1; host_wr = 1'($urandom_range(1));
            host_addr = AW'($urandom); host_wdata = DW'($urandom);
            rand_cpu(); step();
            check("dropped_rvalid", host_rvalid, 0);
        end

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19) == 0) host_req = ~host_req;
            if (!host_req && !host_gnt && $urandom_range(29) == 0) cpu_halted = ~cpu_halted;
            host_valid = 1'($urandom_range(1)); host_wr = 1'($urandom_range(1));
            host_addr = AW'($urandom_range(7)); host_wdata = DW'($urandom);
            rand_cpu(); step();
        end

        // Async reset during a session with a read in flight.
        host_req = 1'b0; host_valid = 1'b0; cpu_halted = 1'b0;
        step(); step();
        host_req = 1'b1;
        k = 0;
        while (!host_gnt && k < 30) begin rand_cpu(); step(); k++; end
        check("grant_before_reset", host_gnt, 1);
        host_valid = 1'b1; host_wr = 1'b0; host_addr = 5;
        @(posedge clk);
        #2;
        rst = 1'b1; host_wr = 1'b1; cpu_wr = 1'b0;
        #1;
        check("async_reset_outputs", {host_gnt, cpu_stall, host_rvalid, host_rdata}, 0);
        check("async_reset_mux", {mem_addr, mem_rd, mem_wr, mem_wdata},
              {cpu_addr, cpu_rd, cpu_wr, cpu_wdata});
        step(); step();
        rst = 1'b0; host_valid = 1'b0; host_req = 1'b0;
        for (int i = 0; i < 5; i++) begin rand_cpu(); step(); end

        check("scoreboard_drained", exp_cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
